led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//  Consumer end of the board->colour path: takes the packed 8x8 RGB frame
//  ([7:0][23:0], 3 bits/cell) produced by the board translator and scans it
//  onto the physical LED matrix. Per row: serial column shift, latch pulse,
//  one-hot row enable and a display dwell. Double-buffered; frames swap only
//  at row-0 boundaries, so a scan never shows a torn frame.
// PARAMETERS
//  ROWS      8   matrix rows; frame row r = frame[r]
//  COLS      8   cells per row; row word = COLS*3 bits
//  CLK_DIV   4   clk cycles per sh_clk half-period (>=1)
//  ROW_HOLD  256 clk cycles a row is displayed (oe_n low), >=1
// PORTS
//  clk          in   1              system clock, rising edge
//  reset        in   1              synchronous, active-high
//  frame        in   [ROWS-1:0][COLS*3-1:0]  colour frame from translator
//  frame_valid  in   1              1-cycle strobe: capture frame
//  sh_clk       out  1              column shift-register clock
//  sh_data      out  1              column serial data, MSB first
//  sh_latch     out  1              column register latch strobe
//  row_en       out  ROWS           one-hot active-high row select
//  oe_n         out  1              output enable, active-low (1=blank)
//  frame_done   out  1              1-cycle pulse after last row dwell
//  busy         out  1              1 whenever state != IDLE
// BEHAVIOUR
//  Reset (sync, active-high, any cycle incl. mid-shift): next edge gives
//   sh_clk=0 sh_data=0 sh_latch=0 row_en=0 oe_n=1 frame_done=0 busy=0;
//   pending and active buffers cleared, pending_full=0, row=0, state IDLE.
//  Capture: frame_valid=1 -> pending<=frame, pending_full<=1 same edge;
//   later strobe before swap overwrites pending (newest wins).
//  FSM: IDLE -> LOAD on pending_full. LOAD -> SHIFT -> LATCH -> DISPLAY
//   -> LOAD (next row). Never returns to IDLE except via reset.
//  LOAD (1 cyc): if row==0 and pending_full: active<=pending,
//   pending_full<=0. If frame_valid in same cycle, the incoming frame goes
//   directly to active (pending_full stays 0). Shift reg <= active[row].
//  SHIFT: COLS*3 bits, bit COLS*3-1 first. Per bit: sh_data set, sh_clk=0
//   for CLK_DIV cycles, then sh_clk=1 for CLK_DIV cycles. Data stable
//   across rising sh_clk. Duration COLS*3*2*CLK_DIV cycles; oe_n=1.
//  LATCH (1 cyc): sh_clk=0, sh_latch=1, oe_n=1, row_en<=1<<row.
//  DISPLAY: oe_n=0 for ROW_HOLD cycles, row_en held. On the last cycle:
//   row<=row+1, wrapping ROWS-1 -> 0; on wrap frame_done=1 for 1 cycle.
//  Row period = 2 + COLS*3*2*CLK_DIV + ROW_HOLD cycles (default 450).
//  row_en is 0 only in reset/IDLE, then always exactly one-hot.
//  Counters sized $clog2 of their max; no overflow past terminal counts.
// CONFIGURATION
//  LED_SCAN_DIM_EN defined: adds input brightness[3:0]. In DISPLAY, oe_n=0
//   only for the first (ROW_HOLD*brightness)>>4 cycles (floor), then 1 for
//   the rest; the dwell length is unchanged. brightness=0 -> fully blank;
//   the value is sampled in LATCH.
//  Undefined: no brightness port; oe_n=0 for the whole dwell.
// TESTING  (CLK_DIV=1, ROW_HOLD=4 unless stated; row period 54)
//  1 reset, no frame_valid for 100 cyc -> busy=0, row_en=0, oe_n=1, no sh_clk.
//  2 frame row0=24'hFFF000, strobe -> 24 sh_clk rises, data 1x12 then 0x12;
//    sh_latch 1 cyc; row_en=8'h01; oe_n low 4 cyc; next row row_en=8'h02.
//  3 run 8 rows -> frame_done pulses once, at cycle 8*54 after first LOAD;
//    row_en wraps 8'h80 -> 8'h01.
//  4 strobe frame B mid-row3 of frame A -> rows 3..7 shift A; row0 shows B.
//    Strobe coincident with row-0 LOAD -> that scan shows the new frame.
//  5 reset asserted mid-SHIFT (bit 10) -> next edge all outputs at reset
//    values; no sh_latch; restarts only after a new frame_valid.
//  6 LED_SCAN_DIM_EN, ROW_HOLD=16, brightness=4 -> oe_n low 4 of 16 cyc;
//    brightness=0 -> oe_n never low; row period unchanged.

Source files
------------

// File: rtl/led_matrix_scanner_if.sv
// Scanner bus: packed colour frame and capture strobe in, LED matrix drive out.
// Defining LED_SCAN_DIM_EN adds a 4-bit brightness input to the bus.
interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic [ROWS-1:0][COLS*3-1:0] frame;
  logic                        frame_valid;
`ifdef LED_SCAN_DIM_EN
  logic [3:0]                  brightness;
`endif
  logic                        sh_clk;
  logic                        sh_data;
  logic                        sh_latch;
  logic [ROWS-1:0]             row_en;
  logic                        oe_n;
  logic                        frame_done;
  logic                        busy;

`ifdef LED_SCAN_DIM_EN
  modport master (
    output frame, frame_valid, brightness,
    input  sh_clk, sh_data, sh_latch, row_en, oe_n, frame_done, busy
  );
  modport slave (
    input  frame, frame_valid, brightness,
    output sh_clk, sh_data, sh_latch, row_en, oe_n, frame_done, busy
  );
`else
  modport master (
    output frame, frame_valid,
    input  sh_clk, sh_data, sh_latch, row_en, oe_n, frame_done, busy
  );
  modport slave (
    input  frame, frame_valid,
    output sh_clk, sh_data, sh_latch, row_en, oe_n, frame_done, busy
  );
`endif
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 RGB LED matrix scanner: serial column shift, latch, one-hot row dwell.
// Optional LED_SCAN_DIM_EN: brightness-scaled oe_n duty inside a fixed-length row dwell.
module led_matrix_scanner #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 256
) (
  input  logic               clk,
  input  logic               reset,
  led_matrix_scanner_if.slave scan
);
  localparam int W  = COLS * 3;
  localparam int RW = (ROWS > 1)     ? $clog2(ROWS)     : 1;
  localparam int BW = (W > 1)        ? $clog2(W)        : 1;
  localparam int DW = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;
  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  state_t state;
  state_t next_state;

  logic [ROWS-1:0][W-1:0] pending;
  logic [ROWS-1:0][W-1:0] active;
  logic                   pending_full;
  logic [RW-1:0]          row;
  logic [W-1:0]           shreg;
  logic [BW-1:0]          bit_cnt;
  logic [DW-1:0]          div_cnt;
  logic                   phase;
  logic [HW-1:0]          hold_cnt;
  logic [ROWS-1:0]        row_en_q;
  logic                   frame_done_q;
  logic                   lit;

  logic div_done;
  logic bit_done;
  logic hold_done;

  assign div_done  = (div_cnt == DIV_LAST);
  assign bit_done  = phase && div_done && (bit_cnt == BIT_LAST);
  assign hold_done = (hold_cnt == HOLD_LAST);

`ifdef LED_SCAN_DIM_EN
  logic [HW-1:0] on_cnt;
  assign lit = (hold_cnt < on_cnt);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    scan.sh_clk   = 1'b0;
    scan.sh_data  = 1'b0;
    scan.sh_latch = 1'b0;
    scan.oe_n     = 1'b1;
    scan.busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (pending_full) next_state = LOAD;
      end
      LOAD: begin
        next_state = SHIFT;
      end
      SHIFT: begin
        scan.sh_clk  = phase;
        scan.sh_data = shreg[W-1];
        if (bit_done) next_state = LATCH;
      end
      LATCH: begin
        scan.sh_latch = 1'b1;
        next_state    = DISPLAY;
      end
      DISPLAY: begin
        scan.oe_n = ~lit;
        if (hold_done) next_state = LOAD;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign scan.row_en     = row_en_q;
  assign scan.frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      active       <= '0;
      pending_full <= 1'b0;
      row          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      phase        <= 1'b0;
      hold_cnt     <= '0;
      row_en_q     <= '0;
      frame_done_q <= 1'b0;
`ifdef LED_SCAN_DIM_EN
      on_cnt       <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if (scan.frame_valid) begin
        pending      <= scan.frame;
        pending_full <= 1'b1;
      end

      case (state)
        LOAD: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          phase   <= 1'b0;
          // Row-0 swap: a strobe in this very cycle bypasses pending and wins.
          if (row == '0 && scan.frame_valid) begin
            active       <= scan.frame;
            pending_full <= 1'b0;
            shreg        <= scan.frame[0];
          end else if (row == '0 && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
            shreg        <= pending[0];
          end else begin
            shreg <= active[row];
          end
        end

        SHIFT: begin
          if (div_done) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
              shreg <= {shreg[W-2:0], 1'b0};
              if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        LATCH: begin
          row_en_q <= ROWS'(1) << row;
          hold_cnt <= '0;
`ifdef LED_SCAN_DIM_EN
          on_cnt   <= HW'((ROW_HOLD * 32'(scan.brightness)) >> 4);
`endif
        end

        DISPLAY: begin
          if (hold_done) begin
            hold_cnt <= '0;
            if (row == ROW_LAST) begin
              row          <= '0;
              frame_done_q <= 1'b1;
            end else begin
              row <= row + RW'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomized bench for led_matrix_scanner: per-cycle comparison against a timeline model
// that derives every output from the cycle offset since the first row-0 load.
`timescale 1ns/1ps
module tb_led_matrix_scanner;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int W       = COLS * 3;
  localparam int CLK_DIV = 1;
`ifdef LED_SCAN_DIM_EN
  localparam int ROW_HOLD = 16;
`else
  localparam int ROW_HOLD = 4;
`endif
  localparam int SH   = W * 2 * CLK_DIV;
  localparam int L    = 2 + SH + ROW_HOLD;
  localparam int SCAN = ROWS * L;

  typedef logic [ROWS-1:0][W-1:0] frame_t;
  typedef struct packed {
    logic            sh_clk;
    logic            sh_data;
    logic            sh_latch;
    logic [ROWS-1:0] row_en;
    logic            oe_n;
    logic            frame_done;
    logic            busy;
  } outs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) scan_bus();

  led_matrix_scanner #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .CLK_DIV (CLK_DIV),
    .ROW_HOLD(ROW_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .scan (scan_bus)
  );

  always #5 clk = ~clk;

  int     cyc         = 0;
  int     c0          = -1;
  int     bright      = 15;
  int     vectors     = 0;
  int     miscompares = 0;
  int     st_cyc[$];
  frame_t st_frm[$];

  function automatic frame_t rand_frame();
    frame_t f;
    for (int r = 0; r < ROWS; r++) f[r] = W'($urandom);
    return f;
  endfunction

  // Timeline model: a scan starting at a row-0 load shows the newest frame strobed at or before it.
  function automatic outs_t expected();
    outs_t    e;
    int       k, o, row, sc, b, d, on;
    frame_t   f;
    logic [W-1:0] word;
    e      = '0;
    e.oe_n = 1'b1;
    if (c0 < 0 || cyc < c0) return e;
    k      = cyc - c0;
    e.busy = 1'b1;
    sc     = k / SCAN;
    row    = (k / L) % ROWS;
    o      = k % L;
    if (k >= SH + 2) e.row_en = ROWS'(1) << (((k - (SH + 2)) / L) % ROWS);
    f = '0;
    foreach (st_cyc[i]) if (st_cyc[i] <= c0 + sc * SCAN) f = st_frm[i];
    word = f[row];
    if (o == 0) begin
      e.frame_done = (k >= SCAN) && (k % SCAN == 0);
    end else if (o <= SH) begin
      b         = (o - 1) / (2 * CLK_DIV);
      e.sh_clk  = ((o - 1) % (2 * CLK_DIV)) >= CLK_DIV;
      e.sh_data = word[W-1-b];
    end else if (o == SH + 1) begin
      e.sh_latch = 1'b1;
    end else begin
      d = o - SH - 2;
`ifdef LED_SCAN_DIM_EN
      on = (ROW_HOLD * bright) >> 4;
`else
      on = ROW_HOLD;
`endif
      e.oe_n = !(d < on);
    end
    return e;
  endfunction

  function automatic outs_t observed();
    outs_t s;
    s.sh_clk     = scan_bus.sh_clk;
    s.sh_data    = scan_bus.sh_data;
    s.sh_latch   = scan_bus.sh_latch;
    s.row_en     = scan_bus.row_en;
    s.oe_n       = scan_bus.oe_n;
    s.frame_done = scan_bus.frame_done;
    s.busy       = scan_bus.busy;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    scan_bus.frame_valid = 1'b0;
  endtask

  task automatic strobe(input frame_t f);
    scan_bus.frame       = f;
    scan_bus.frame_valid = 1'b1;
    st_cyc.push_back(cyc);
    st_frm.push_back(f);
    if (c0 < 0) c0 = cyc + 2;
  endtask

  task automatic test_reset();
    outs_t e, o;
    reset                = 1'b1;
    scan_bus.frame       = '0;
    scan_bus.frame_valid = 1'b0;
    repeat (3) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h expected=%h", cyc, o, e);
      end
    end
    reset = 1'b0;
    repeat (100) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%h expected=%h", cyc, o, e);
      end
    end
  endtask

  task automatic test_first_frame();
    frame_t fa;
    outs_t  e, o;
    int     rises, latches;
    logic   prev;
    rises = 0; latches = 0; prev = 1'b0;
    fa    = rand_frame();
    fa[0] = 24'hFFF000;
    strobe(fa);
    while (cyc < c0 + 2 * L) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL first_frame cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (cyc >= c0 && cyc < c0 + L) begin
        if (o.sh_clk && !prev) rises++;
        if (o.sh_latch) latches++;
      end
      prev = o.sh_clk;
    end
    vectors++;
    if (rises !== 24) begin
      miscompares++;
      $display("FAIL row0_sh_clk_rises got=%0d expected=24", rises);
    end
    vectors++;
    if (latches !== 1) begin
      miscompares++;
      $display("FAIL row0_latch_pulses got=%0d expected=1", latches);
    end
  endtask

  task automatic test_full_scan();
    outs_t e, o;
    int    pulses, pulse_cyc;
    pulses = 0; pulse_cyc = -1;
    while (cyc < c0 + SCAN + L) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_scan cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      if (o.frame_done) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL frame_done_count got=%0d expected=1", pulses);
    end
    vectors++;
    if (pulse_cyc !== c0 + SCAN) begin
      miscompares++;
      $display("FAIL frame_done_position got=%0d expected=%0d", pulse_cyc, c0 + SCAN);
    end
  endtask

  task automatic test_back_to_back();
    frame_t fb, fb2, fb3, fc;
    outs_t  e, o;
    int     k;
    fb = rand_frame(); fb2 = rand_frame(); fb3 = rand_frame(); fc = rand_frame();
    while (cyc < c0 + 4 * SCAN + L) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL frame_swap cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      k = cyc - c0;
      if (k == SCAN + 3 * L + 10)          strobe(fb);
      else if (k == 2 * SCAN + 2 * L + 7)  strobe(fb2);
      else if (k == 2 * SCAN + 5 * L + 30) strobe(fb3);
      else if (k == 4 * SCAN)              strobe(fc);
    end
  endtask

  task automatic test_reset_mid_shift();
    frame_t fe, ff;
    outs_t  e, o;
    int     k, guard;
    logic   done;
    fe = rand_frame(); ff = rand_frame();
    done = 1'b0; guard = 0;
    while (!done && guard < 2 * SCAN) begin
      step();
      guard++;
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pre_reset cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      k = cyc - c0;
      if (k == 4 * SCAN + L + 5) strobe(fe);
      else if (k == 4 * SCAN + L + 1 + 10 * 2 * CLK_DIV) begin
        reset = 1'b1;
        c0    = -1;
        st_cyc.delete();
        st_frm.delete();
        done  = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL reset_point_reached got=0 expected=1");
    end
    step();
    e = expected(); o = observed(); vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_mid_shift cyc=%0d got=%h expected=%h", cyc, o, e);
    end
    reset = 1'b0;
    repeat (80) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc=%0d got=%h expected=%h", cyc, o, e);
      end
    end
    strobe(ff);
    repeat (L + 12) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL restart cyc=%0d got=%h expected=%h", cyc, o, e);
      end
    end
  endtask

`ifdef LED_SCAN_DIM_EN
  task automatic test_dimming();
    outs_t e, o;
    int    k, rowi, lows, stop;
    rowi = 0; lows = 0;
    stop = cyc - c0 + 12 * L;
    while (cyc - c0 < stop) begin
      step();
      e = expected(); o = observed(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL dimming cyc=%0d got=%h expected=%h", cyc, o, e);
      end
      k = cyc - c0;
      if (k % L == 0) begin
        if (rowi == 1) begin
          vectors++;
          if (lows !== 4) begin
            miscompares++;
            $display("FAIL dim4_oe_low got=%0d expected=4", lows);
          end
        end
        if (rowi == 2) begin
          vectors++;
          if (lows !== 0) begin
            miscompares++;
            $display("FAIL dim0_oe_low got=%0d expected=0", lows);
          end
        end
        rowi++;
        lows   = 0;
        bright = (rowi == 1) ? 4 : (rowi == 2) ? 0 : int'($urandom_range(0, 15));
        scan_bus.brightness = 4'(bright);
      end
      if (!o.oe_n) lows++;
    end
  endtask
`endif

  initial begin
`ifdef LED_SCAN_DIM_EN
    scan_bus.brightness = 4'(bright);
`endif
    test_reset();
    test_first_frame();
    test_full_scan();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef LED_SCAN_DIM_EN
    test_dimming();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
